// File: rtl/mips_ctl_defs.sv
// Shared definitions for the multi-cycle MIPS control unit and its datapath.
// Holds the controller state codes, the opcode constants, the encodings of
// the ALUop / ALUsrcB / PCSource selects, and the opcode-to-first-state
// decode shared by the sequencer and the output decoder.
package mips_ctl_defs;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_SHIMM = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // State entered from DECODE for a 6-bit opcode. S_FETCH doubles as the
  // "illegal opcode" answer, since unknown opcodes simply go back to fetch.
  function automatic state_e decode_target(input logic [5:0] op,
                                           input logic       ext_ops);
    state_e tgt;
    tgt = S_FETCH;
    case (op)
      OPC_LW, OPC_SW: tgt = S_MEMADR;
      OPC_RTYPE:      tgt = S_EXEC;
      OPC_BEQ:        tgt = S_BRANCH;
      OPC_BNE:        tgt = ext_ops ? S_BRANCH : S_FETCH;
      OPC_J:          tgt = S_JUMP;
      OPC_ADDI:       tgt = ext_ops ? S_ADDIEX : S_FETCH;
      default:        tgt = S_FETCH;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/multi_ctl_outdec.sv
// Output decoder of the multi-cycle control unit.
// Purely combinational: turns the current state, the live opcode, the
// opcode latched in DECODE and the (possibly gated) memory-ready flag into
// the datapath strobes and selects.
// Ports:
//   state      in   current controller state
//   op         in   live opcode (only looked at in DECODE, for illegal_op)
//   op_q       in   opcode latched in DECODE (selects BranchNe)
//   mem_ok     in   memory access completes this cycle
//   PCWrite..RegDst, ALUsrcB, ALUop, PCSource  out  datapath controls
//   illegal_op out   high in DECODE when the opcode is not recognised
module multi_ctl_outdec
  import mips_ctl_defs::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter bit          EXT_OPS = 1'b1
) (
  input  state_e          state,
  input  logic [OP_W-1:0] op,
  input  logic [OP_W-1:0] op_q,
  input  logic            mem_ok,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            BranchNe,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            MemtoReg,
  output logic            IRWrite,
  output logic            ALUsrcA,
  output logic            RegWrite,
  output logic            RegDst,
  output logic [1:0]      ALUsrcB,
  output logic [1:0]      ALUop,
  output logic [1:0]      PCSource,
  output logic            illegal_op
);

  logic op_illegal;

  // Everything defaults to 0 so each state only names what it asserts;
  // unused state codes fall through with all outputs low.
  always_comb begin
    op_illegal = (decode_target(op[5:0], EXT_OPS) == S_FETCH);
    // Opcode bits above the 6-bit field must be zero to be recognised.
    if (op != OP_W'(op[5:0])) op_illegal = 1'b1;

    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUsrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUsrcB     = SRCB_REG;
    ALUop       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    illegal_op  = 1'b0;

    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUsrcB = SRCB_FOUR;
        // Only capture the instruction and bump the PC when the read lands.
        IRWrite = mem_ok;
        PCWrite = mem_ok;
      end
      S_DECODE: begin
        ALUsrcB    = SRCB_SHIMM;
        illegal_op = op_illegal;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUsrcA = 1'b1;
        ALUsrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_EXEC: begin
        ALUsrcA = 1'b1;
        ALUop   = ALUOP_FUNCT;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUsrcA     = 1'b1;
        ALUop       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        BranchNe    = (op_q == OP_W'(OPC_BNE));
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_ctl.sv
// Multi-cycle MIPS control unit (Moore sequencer with mem_ready gating).
// Holds the state register and the opcode latch; output decode lives in
// multi_ctl_outdec.
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   OP          in   opcode, sampled in DECODE
//   mem_ready   in   memory access completes this cycle
//   PCWrite..RegDst  out  1-bit datapath strobes/selects
//   ALUsrcB, ALUop, PCSource  out  2-bit selects
//   state       out  current state code (debug)
//   illegal_op  out  pulse in DECODE on an unknown opcode
module multi_ctl
  import mips_ctl_defs::*;
#(
  parameter int unsigned OP_W        = 6,
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter bit          EXT_OPS     = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] OP,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            BranchNe,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            MemtoReg,
  output logic            IRWrite,
  output logic            ALUsrcA,
  output logic            RegWrite,
  output logic            RegDst,
  output logic [1:0]      ALUsrcB,
  output logic [1:0]      ALUop,
  output logic [1:0]      PCSource,
  output logic [3:0]      state,
  output logic            illegal_op
);

  state_e          state_q, state_d;
  state_e          op_target;
  logic [OP_W-1:0] op_q, op_d;
  logic            mem_ok;

  // With waiting disabled the memory is assumed to always answer at once.
  assign mem_ok = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state  = state_q;

  // Next state and opcode latch. The opcode is only captured in DECODE so
  // that later sequencing ignores whatever the datapath puts on OP.
  always_comb begin
    op_target = decode_target(OP[5:0], EXT_OPS);
    if (OP != OP_W'(OP[5:0])) op_target = S_FETCH;

    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_FETCH:  if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        op_d    = OP;
        state_d = op_target;
      end
      S_MEMADR: state_d = (op_q == OP_W'(OPC_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ok) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ok) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Reset is asynchronous so an in-flight memory write is dropped at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  multi_ctl_outdec #(
    .OP_W    (OP_W),
    .EXT_OPS (EXT_OPS)
  ) u_outdec (
    .state       (state_q),
    .op          (OP),
    .op_q        (op_q),
    .mem_ok      (mem_ok),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .BranchNe    (BranchNe),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .ALUsrcA     (ALUsrcA),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .ALUsrcB     (ALUsrcB),
    .ALUop       (ALUop),
    .PCSource    (PCSource),
    .illegal_op  (illegal_op)
  );

endmodule

// File: tb/tb_multi_ctl.sv
// Self-checking bench for multi_ctl. The main instance uses the default
// parameters; a second instance has EXT_OPS=0 and MEM_WAIT_EN=0.
// Expected behaviour comes from a per-instruction state trace and a table
// of the outputs each state asserts.
module tb_multi_ctl;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic       rst_n, mem_ready;
  logic [5:0] op;
  logic       pcw, pcwc, bne_o, iord, mrd, mwr, m2r, irw, srca, rw, rdst, ill;
  logic [1:0] srcb, aluop, pcsrc;
  logic [3:0] st;
  logic [17:0] dut_out;

  // Second instance signals
  logic       rst2_n, mr2;
  logic [5:0] op2;
  logic       pcw2, pcwc2, bne2, iord2, mrd2, mwr2, m2r2, irw2, srca2, rw2, rdst2, ill2;
  logic [1:0] srcb2, aluop2, pcsrc2;
  logic [3:0] st2;

  int total = 0;
  int bad   = 0;
  int cyc_no = 0;
  logic [5:0] op_lat;

  assign dut_out = {pcw, pcwc, bne_o, iord, mrd, mwr, m2r, irw, srca, rw, rdst,
                    srcb, aluop, pcsrc, ill};

  multi_ctl dut (
    .clk(clk), .rst_n(rst_n), .OP(op), .mem_ready(mem_ready),
    .PCWrite(pcw), .PCWriteCond(pcwc), .BranchNe(bne_o), .IorD(iord),
    .MemRead(mrd), .MemWrite(mwr), .MemtoReg(m2r), .IRWrite(irw),
    .ALUsrcA(srca), .RegWrite(rw), .RegDst(rdst), .ALUsrcB(srcb),
    .ALUop(aluop), .PCSource(pcsrc), .state(st), .illegal_op(ill)
  );

  multi_ctl #(.OP_W(6), .MEM_WAIT_EN(1'b0), .EXT_OPS(1'b0)) dut2 (
    .clk(clk), .rst_n(rst2_n), .OP(op2), .mem_ready(mr2),
    .PCWrite(pcw2), .PCWriteCond(pcwc2), .BranchNe(bne2), .IorD(iord2),
    .MemRead(mrd2), .MemWrite(mwr2), .MemtoReg(m2r2), .IRWrite(irw2),
    .ALUsrcA(srca2), .RegWrite(rw2), .RegDst(rdst2), .ALUsrcB(srcb2),
    .ALUop(aluop2), .PCSource(pcsrc2), .state(st2), .illegal_op(ill2)
  );

  function automatic bit is_legal(input logic [5:0] o, input bit ext);
    logic [5:0] legal_ops [7];
    int n;
    legal_ops = '{LW, SW, RT, BEQ, JMP, BNE, ADDI};
    n = ext ? 7 : 5;
    for (int i = 0; i < n; i++)
      if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  // Outputs each state is required to drive; anything not named is 0.
  function automatic logic [17:0] exp_out(input int s, input logic [5:0] lat,
                                          input logic [5:0] cur, input logic mr,
                                          input bit ext);
    logic e_pcw, e_pcwc, e_bne, e_iord, e_mrd, e_mwr, e_m2r, e_irw, e_srca, e_rw, e_rdst, e_ill;
    logic [1:0] e_srcb, e_aluop, e_pcsrc;
    e_pcw = 0; e_pcwc = 0; e_bne = 0; e_iord = 0; e_mrd = 0; e_mwr = 0;
    e_m2r = 0; e_irw = 0; e_srca = 0; e_rw = 0; e_rdst = 0; e_ill = 0;
    e_srcb = 2'd0; e_aluop = 2'd0; e_pcsrc = 2'd0;
    case (s)
      0:  begin e_mrd = 1; e_srcb = 2'd1; e_irw = mr; e_pcw = mr; end
      1:  begin e_srcb = 2'd3; e_ill = !is_legal(cur, ext); end
      2, 10: begin e_srca = 1; e_srcb = 2'd2; end
      3:  begin e_mrd = 1; e_iord = 1; end
      4:  begin e_rw = 1; e_m2r = 1; end
      5:  begin e_mwr = 1; e_iord = 1; end
      6:  begin e_srca = 1; e_aluop = 2'b10; end
      7:  begin e_rw = 1; e_rdst = 1; end
      8:  begin e_srca = 1; e_aluop = 2'b01; e_pcwc = 1; e_pcsrc = 2'd1; e_bne = (lat == BNE); end
      9:  begin e_pcw = 1; e_pcsrc = 2'd2; end
      11: e_rw = 1;
      default: ;
    endcase
    return {e_pcw, e_pcwc, e_bne, e_iord, e_mrd, e_mwr, e_m2r, e_irw, e_srca,
            e_rw, e_rdst, e_srcb, e_aluop, e_pcsrc, e_ill};
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle on the main instance: drive at the falling edge, check
  // just after, and let the next rising edge advance the design.
  task automatic applyStimulus(input int exp_st, input logic mr, input logic [5:0] o);
    @(negedge clk);
    mem_ready = mr;
    op = o;
    #1;
    checkOutput($sformatf("state c%0d", cyc_no), {28'd0, st}, exp_st);
    checkOutput($sformatf("outs c%0d st%0d", cyc_no, exp_st), {14'd0, dut_out},
                {14'd0, exp_out(exp_st, op_lat, o, mr, 1'b1)});
    if (exp_st == 1) op_lat = o;
    cyc_no++;
  endtask

  // Full instruction trace: fetch (with stalls), decode, then the
  // opcode-specific states. Non-decode cycles carry random garbage on OP.
  task automatic run_instr(input logic [5:0] o, input int fstall, input int mstall);
    for (int i = 0; i < fstall; i++) applyStimulus(0, 1'b0, rnd6());
    applyStimulus(0, 1'b1, rnd6());
    applyStimulus(1, rnd1(), o);
    if (o == LW) begin
      applyStimulus(2, rnd1(), rnd6());
      for (int i = 0; i < mstall; i++) applyStimulus(3, 1'b0, rnd6());
      applyStimulus(3, 1'b1, rnd6());
      applyStimulus(4, rnd1(), rnd6());
    end else if (o == SW) begin
      applyStimulus(2, rnd1(), rnd6());
      for (int i = 0; i < mstall; i++) applyStimulus(5, 1'b0, rnd6());
      applyStimulus(5, 1'b1, rnd6());
    end else if (o == RT) begin
      applyStimulus(6, rnd1(), rnd6());
      applyStimulus(7, rnd1(), rnd6());
    end else if (o == BEQ || o == BNE) begin
      applyStimulus(8, rnd1(), rnd6());
    end else if (o == JMP) begin
      applyStimulus(9, rnd1(), rnd6());
    end else if (o == ADDI) begin
      applyStimulus(10, rnd1(), rnd6());
      applyStimulus(11, rnd1(), rnd6());
    end
  endtask

  task automatic applyStim2(input int exp_st, input logic [5:0] o, input logic exp_ill);
    @(negedge clk);
    mr2 = 1'b0;
    op2 = o;
    #1;
    checkOutput($sformatf("ext0 state c%0d", cyc_no), {28'd0, st2}, exp_st);
    checkOutput($sformatf("ext0 illegal c%0d", cyc_no), {31'd0, ill2}, {31'd0, exp_ill});
    cyc_no++;
  endtask

  initial begin
    logic [5:0] pick_tab [9];
    logic [5:0] o;
    int idx;
    pick_tab = '{LW, SW, RT, BEQ, BNE, JMP, ADDI, 6'h3f, 6'h11};

    rst_n = 1'b0; mem_ready = 1'b0; op = 6'd0;
    rst2_n = 1'b0; mr2 = 1'b0; op2 = 6'd0;
    op_lat = 6'd0;
    #2;
    checkOutput("reset state", {28'd0, st}, 0);
    checkOutput("reset outs", {14'd0, dut_out}, {14'd0, exp_out(0, 6'd0, 6'd0, 1'b0, 1'b1)});
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed instruction traces");
    run_instr(LW, 0, 0);
    run_instr(SW, 0, 3);
    run_instr(RT, 0, 0);
    run_instr(BEQ, 0, 0);
    run_instr(JMP, 0, 0);
    run_instr(LW, 2, 1);
    run_instr(BNE, 0, 0);
    run_instr(ADDI, 1, 0);
    run_instr(6'b111111, 0, 0);

    $display("[TB] randomized instruction stream");
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 9);
      o = (idx == 9) ? rnd6() : pick_tab[idx];
      run_instr(o, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("[TB] reset during stalled MEMRD");
    applyStimulus(0, 1'b1, rnd6());
    applyStimulus(1, 1'b1, LW);
    applyStimulus(2, 1'b1, rnd6());
    applyStimulus(3, 1'b0, rnd6());
    #1 rst_n = 1'b0;
    op_lat = 6'd0;
    #1;
    checkOutput("async rst state", {28'd0, st}, 0);
    checkOutput("async rst outs", {14'd0, dut_out}, {14'd0, exp_out(0, op_lat, op, mem_ready, 1'b1)});
    @(posedge clk);
    #1;
    checkOutput("held in rst", {28'd0, st}, 0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(RT, 1, 0);

    $display("[TB] reset during stalled MEMWR");
    applyStimulus(0, 1'b1, rnd6());
    applyStimulus(1, 1'b1, SW);
    applyStimulus(2, 1'b1, rnd6());
    applyStimulus(5, 1'b0, rnd6());
    #1 rst_n = 1'b0;
    op_lat = 6'd0;
    #1;
    checkOutput("memwr rst MemWrite", {31'd0, mwr}, 0);
    checkOutput("memwr rst state", {28'd0, st}, 0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(BNE, 0, 0);

    $display("[TB] EXT_OPS=0, MEM_WAIT_EN=0 instance");
    @(negedge clk);
    mr2 = 1'b0;
    op2 = 6'd0;
    #1;
    checkOutput("ext0 reset state", {28'd0, st2}, 0);
    checkOutput("ext0 fetch no wait IRWrite", {31'd0, irw2}, 1);
    rst2_n = 1'b1;
    applyStim2(1, BNE, 1'b1);
    applyStim2(0, rnd6(), 1'b0);
    applyStim2(1, ADDI, 1'b1);
    applyStim2(0, rnd6(), 1'b0);
    applyStim2(1, BEQ, 1'b0);
    applyStim2(8, rnd6(), 1'b0);
    checkOutput("ext0 beq BranchNe", {31'd0, bne2}, 0);
    applyStim2(0, rnd6(), 1'b0);
    applyStim2(1, LW, 1'b0);
    applyStim2(2, rnd6(), 1'b0);
    applyStim2(3, rnd6(), 1'b0);
    applyStim2(4, rnd6(), 1'b0);
    applyStim2(0, rnd6(), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
